simple_top_ip_parity_init: RTL and testbench

//  Initiator-side parity block for the SIMPLE_TOP bus.
//  - Generates WADDR/WDATA/RADDR parity for outgoing beats.
//  - Checks RDATA parity on returning beats; reports errors as a registered complementary pair, a sticky flag and a saturating counter.
//  - Provides an edge-armed fault-injection FSM to exercise both the remote and local checkers.

---
 rtl/simple_top_ip_parity_init.sv | 128 ++++++++++++
 tb/tb_simple_top_ip_parity_init.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/simple_top_ip_parity_init.sv
// Initiator-side parity for the SIMPLE_TOP bus: generates outgoing parity, checks
// returning read data, and hosts an edge-armed fault-injection FSM.
module simple_top_ip_parity_init #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              ACLK,
    input  logic              RESET_ACLK,
    input  logic              ENERR,
    input  logic              FIERR,
    input  logic              ERR_CLR,
    input  logic [ADDR_W-1:0] WADDR_DATA,
    input  logic              WADDR_VALID,
    output logic              WADDR_PARITY,
    input  logic [DATA_W-1:0] WDATA_DATA,
    input  logic              WDATA_VALID,
    output logic              WDATA_PARITY,
    input  logic [ADDR_W-1:0] RADDR_DATA,
    input  logic              RADDR_VALID,
    output logic              RADDR_PARITY,
    input  logic [DATA_W-1:0] RDATA_DATA,
    input  logic              RDATA_PARITY,
    input  logic              RDATA_VALID,
    output logic              ERR_RDATA_PARITY,
    output logic              ERR_RDATA_PARITY_B,
    output logic              ERR_STICKY,
    output logic [CNT_W-1:0]  ERR_CNT
);

    // Bit 1 = write-address injection pending, bit 0 = read-data injection pending.
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RX_ONLY = 2'b01,
        S_TX_ONLY = 2'b10,
        S_ARMED   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [SYNC_STAGES-1:0] r_en_sync;
    logic [SYNC_STAGES-1:0] r_fi_sync;
    logic                   r_fi_q;
    state_t                 r_state;
    state_t                 w_next;
    logic                   r_err;
    logic                   r_sticky;
    logic [CNT_W-1:0]       r_cnt;

    logic w_en_s;
    logic w_fi_s;
    logic w_fi_edge;
    logic w_tx_inj;
    logic w_rx_inj;
    logic w_mis;

    assign w_en_s    = r_en_sync[SYNC_STAGES-1];
    assign w_fi_s    = r_fi_sync[SYNC_STAGES-1];
    assign w_fi_edge = w_fi_s & ~r_fi_q;
    assign w_tx_inj  = r_state[1] & WADDR_VALID;
    assign w_rx_inj  = r_state[0] & RDATA_VALID;

    assign WADDR_PARITY = (WADDR_VALID & (^WADDR_DATA)) ^ w_tx_inj;
    assign WDATA_PARITY = WDATA_VALID & (^WDATA_DATA);
    assign RADDR_PARITY = RADDR_VALID & (^RADDR_DATA);

    assign w_mis = RDATA_VALID & ((^RDATA_DATA) ^ RDATA_PARITY ^ w_rx_inj);

    always_ff @(posedge ACLK) begin
        if (RESET_ACLK) begin
            r_en_sync <= '0;
            r_fi_sync <= '0;
            r_fi_q    <= 1'b0;
        end else begin
            r_en_sync <= {r_en_sync[SYNC_STAGES-2:0], ENERR};
            r_fi_sync <= {r_fi_sync[SYNC_STAGES-2:0], FIERR};
            r_fi_q    <= w_fi_s;
        end
    end

    always_ff @(posedge ACLK) begin
        if (RESET_ACLK) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // A new request re-arms both bits even if a beat consumes one this cycle.
    always_comb begin
        w_next = r_state;
        if (w_fi_edge) begin
            w_next = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED:   w_next = state_t'({~w_tx_inj, ~w_rx_inj});
                S_TX_ONLY: if (w_tx_inj) w_next = S_IDLE;
                S_RX_ONLY: if (w_rx_inj) w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (RESET_ACLK) begin
            r_err    <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_err <= w_mis & w_en_s;
            if (r_err) begin
                r_sticky <= 1'b1;
                r_cnt    <= ERR_CLR ? CNT_ONE : sat_inc(r_cnt);
            end else if (ERR_CLR) begin
                r_sticky <= 1'b0;
                r_cnt    <= '0;
            end
        end
    end

    assign ERR_RDATA_PARITY   = r_err;
    assign ERR_RDATA_PARITY_B = ~r_err;
    assign ERR_STICKY         = r_sticky;
    assign ERR_CNT            = r_cnt;

endmodule

// File: tb/tb_simple_top_ip_parity_init.sv
// Directed bench for simple_top_ip_parity_init built with a 2-bit error counter.
module tb_simple_top_ip_parity_init;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 2;

    logic              ACLK = 1'b0;
    logic              RESET_ACLK;
    logic              ENERR, FIERR, ERR_CLR;
    logic [ADDR_W-1:0] WADDR_DATA;
    logic              WADDR_VALID;
    logic              WADDR_PARITY;
    logic [DATA_W-1:0] WDATA_DATA;
    logic              WDATA_VALID;
    logic              WDATA_PARITY;
    logic [ADDR_W-1:0] RADDR_DATA;
    logic              RADDR_VALID;
    logic              RADDR_PARITY;
    logic [DATA_W-1:0] RDATA_DATA;
    logic              RDATA_PARITY;
    logic              RDATA_VALID;
    logic              ERR_RDATA_PARITY;
    logic              ERR_RDATA_PARITY_B;
    logic              ERR_STICKY;
    logic [CNT_W-1:0]  ERR_CNT;

    int n_checks = 0;
    int n_errors = 0;

    simple_top_ip_parity_init #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .SYNC_STAGES(2)
    ) dut (
        .ACLK(ACLK), .RESET_ACLK(RESET_ACLK), .ENERR(ENERR), .FIERR(FIERR),
        .ERR_CLR(ERR_CLR),
        .WADDR_DATA(WADDR_DATA), .WADDR_VALID(WADDR_VALID), .WADDR_PARITY(WADDR_PARITY),
        .WDATA_DATA(WDATA_DATA), .WDATA_VALID(WDATA_VALID), .WDATA_PARITY(WDATA_PARITY),
        .RADDR_DATA(RADDR_DATA), .RADDR_VALID(RADDR_VALID), .RADDR_PARITY(RADDR_PARITY),
        .RDATA_DATA(RDATA_DATA), .RDATA_PARITY(RDATA_PARITY), .RDATA_VALID(RDATA_VALID),
        .ERR_RDATA_PARITY(ERR_RDATA_PARITY), .ERR_RDATA_PARITY_B(ERR_RDATA_PARITY_B),
        .ERR_STICKY(ERR_STICKY), .ERR_CNT(ERR_CNT)
    );

    always #5 ACLK = ~ACLK;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rbeat(input logic [DATA_W-1:0] d, input logic p);
        RDATA_DATA = d; RDATA_PARITY = p; RDATA_VALID = 1'b1;
    endtask

    task automatic idle_bus();
        WADDR_VALID = 1'b0; WDATA_VALID = 1'b0; RADDR_VALID = 1'b0; RDATA_VALID = 1'b0;
        WADDR_DATA = '0; WDATA_DATA = '0; RADDR_DATA = '0; RDATA_DATA = '0; RDATA_PARITY = 1'b0;
    endtask

    task automatic clear_errs();
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    endtask

    initial begin
        RESET_ACLK = 1'b1; ENERR = 1'b0; FIERR = 1'b0; ERR_CLR = 1'b0;
        idle_bus();
        tick(3);
        RESET_ACLK = 1'b0;
        tick();
        check("rst_err",    ERR_RDATA_PARITY,   0);
        check("rst_err_b",  ERR_RDATA_PARITY_B, 1);
        check("rst_sticky", ERR_STICKY,         0);
        check("rst_cnt",    ERR_CNT,            0);

        // Generation is combinational and gated by VALID.
        WADDR_VALID = 1'b1; WADDR_DATA = 32'h0000_0007; #1;
        check("waddr_par_7", WADDR_PARITY, 1);
        WADDR_DATA = 32'h0000_0003; #1;
        check("waddr_par_3", WADDR_PARITY, 0);
        WADDR_VALID = 1'b0; WADDR_DATA = 32'h0000_0007; #1;
        check("waddr_par_novld", WADDR_PARITY, 0);
        WDATA_VALID = 1'b1; WDATA_DATA = 64'h8000_0000_0000_0000; #1;
        check("wdata_par_msb", WDATA_PARITY, 1);
        WDATA_VALID = 1'b0; #1;
        check("wdata_par_novld", WDATA_PARITY, 0);
        RADDR_VALID = 1'b1; RADDR_DATA = 32'hFFFF_FFFE; #1;
        check("raddr_par_odd", RADDR_PARITY, 1);
        idle_bus();

        // Bad read beat with reporting enabled.
        ENERR = 1'b1;
        tick(4);
        rbeat(64'h1, 1'b0); #1;
        check("bad_same_cycle", ERR_RDATA_PARITY, 0);
        tick(); RDATA_VALID = 1'b0;
        check("bad_err_n1",   ERR_RDATA_PARITY,   1);
        check("bad_errb_n1",  ERR_RDATA_PARITY_B, 0);
        check("bad_stk_n1",   ERR_STICKY,         0);
        tick();
        check("bad_err_n2",   ERR_RDATA_PARITY,   0);
        check("bad_errb_n2",  ERR_RDATA_PARITY_B, 1);
        check("bad_sticky",   ERR_STICKY,         1);
        check("bad_cnt",      ERR_CNT,            1);
        rbeat(64'h1, 1'b1);
        tick(); RDATA_VALID = 1'b0;
        check("good_beat_err", ERR_RDATA_PARITY, 0);
        clear_errs();
        tick();
        check("clr_sticky", ERR_STICKY, 0);
        check("clr_cnt",    ERR_CNT,    0);

        // Fault injection: write-address side first.
        FIERR = 1'b1;
        tick(4);
        WADDR_VALID = 1'b1; WADDR_DATA = '0; #1;
        check("inj_waddr_par", WADDR_PARITY, 1);
        tick(); #1;
        check("inj_waddr_next", WADDR_PARITY, 0);
        WADDR_VALID = 1'b0;
        tick(2);
        rbeat(64'h0, 1'b0);
        tick(); RDATA_VALID = 1'b0;
        check("inj_rdata_err", ERR_RDATA_PARITY, 1);
        tick();
        check("inj_rdata_cnt", ERR_CNT, 1);
        rbeat(64'h0, 1'b0);
        tick(); RDATA_VALID = 1'b0;
        check("idle_after_inj", ERR_RDATA_PARITY, 0);
        WADDR_VALID = 1'b1; #1;
        check("idle_waddr_par", WADDR_PARITY, 0);
        WADDR_VALID = 1'b0;
        FIERR = 1'b0;
        clear_errs();

        // Saturation with back-to-back bad beats.
        rbeat(64'h3, 1'b1);
        tick();
        check("b2b_err_1", ERR_RDATA_PARITY, 1);
        tick();
        check("b2b_err_2", ERR_RDATA_PARITY, 1);
        tick(3); RDATA_VALID = 1'b0;
        check("b2b_err_5", ERR_RDATA_PARITY, 1);
        tick();
        check("sat_cnt", ERR_CNT, 3);
        check("sat_sticky", ERR_STICKY, 1);
        rbeat(64'h1, 1'b0);
        tick(); RDATA_VALID = 1'b0; ERR_CLR = 1'b1;
        tick(); ERR_CLR = 1'b0;
        check("clr_vs_err_cnt",    ERR_CNT,    1);
        check("clr_vs_err_sticky", ERR_STICKY, 1);

        // Masked reporting.
        clear_errs();
        ENERR = 1'b0;
        tick(4);
        rbeat(64'h1, 1'b0);
        tick(2); RDATA_VALID = 1'b0;
        check("mask_err", ERR_RDATA_PARITY, 0);
        tick();
        check("mask_cnt", ERR_CNT, 0);

        // Reset while armed drops the pending injection.
        ENERR = 1'b1;
        FIERR = 1'b1;
        tick(4);
        RESET_ACLK = 1'b1; FIERR = 1'b0;
        tick(2);
        RESET_ACLK = 1'b0;
        tick(4);
        WADDR_VALID = 1'b1; WADDR_DATA = '0; #1;
        check("rst_armed_waddr", WADDR_PARITY, 0);
        WADDR_VALID = 1'b0;
        rbeat(64'h0, 1'b0);
        tick(); RDATA_VALID = 1'b0;
        check("rst_armed_rdata", ERR_RDATA_PARITY, 0);
        tick();
        check("rst_armed_cnt", ERR_CNT, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
